// File: rtl/fifo_rd_stream_adapter_if.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream_adapter_if
// Bundles the FIFO read-port signals and the outgoing valid/ready stream of
// fifo_rd_stream_adapter.
//   master : the adapter side (drives fifo_rd_en, m_valid, m_data, level, err)
//   slave  : the surrounding logic (FIFO read controller + stream consumer)
// Signals:
//   fifo_empty     FIFO empty flag
//   fifo_rd_en     read request to the FIFO
//   fifo_rd_data   FIFO read data, meaningful only with fifo_rd_valid
//   fifo_rd_valid  FIFO read-data valid (fixed latency after fifo_rd_en)
//   m_valid/m_ready/m_data  output stream
//   level          words held in the skid buffer
//   err            sticky protocol-error flag
// -----------------------------------------------------------------------------
interface fifo_rd_stream_adapter_if #(
    parameter int DATA_WIDTH = 36,
    parameter int CNT_WIDTH  = 5
);
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_rd_valid;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic [CNT_WIDTH-1:0]  level;
    logic                  err;

    modport master (
        input  fifo_empty, fifo_rd_data, fifo_rd_valid, m_ready,
        output fifo_rd_en, m_valid, m_data, level, err
    );

    modport slave (
        output fifo_empty, fifo_rd_data, fifo_rd_valid, m_ready,
        input  fifo_rd_en, m_valid, m_data, level, err
    );
endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream_adapter
// Turns the fixed-latency read port of the async FIFO (rd_en -> rd_valid after
// READ_LATENCY cycles) into a valid/ready stream with full throughput.
// Reads are issued only while the skid buffer has room for every word already
// requested, so words in the RAM output pipeline always have a slot when the
// consumer stalls.
// Ports:
//   clk  read-domain clock
//   rst  asynchronous active-high reset
//   bus  fifo_rd_stream_adapter_if.master (FIFO read port + output stream,
//        level and err)
// -----------------------------------------------------------------------------
module fifo_rd_stream_adapter #(
    parameter int DATA_WIDTH   = 36,
    parameter int READ_LATENCY = 10,
    parameter int SKID_DEPTH   = 16,
    parameter int CNT_WIDTH    = $clog2(SKID_DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    fifo_rd_stream_adapter_if.master bus
);
    localparam int PTR_WIDTH = $clog2(SKID_DEPTH);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT     = CNT_WIDTH'(SKID_DEPTH);
    localparam logic [CNT_WIDTH:0]   CREDIT_LIMIT = (CNT_WIDTH + 1)'(SKID_DEPTH);

    // Configuration guard: pointers wrap naturally only for a power-of-two
    // depth, and the buffer must cover the whole read pipeline plus one.
    generate
        if (READ_LATENCY < 1 || SKID_DEPTH < READ_LATENCY + 1 ||
            (SKID_DEPTH & (SKID_DEPTH - 1)) != 0) begin : g_bad_cfg
            $error("fifo_rd_stream_adapter: illegal READ_LATENCY/SKID_DEPTH");
        end
    endgenerate

    logic [CNT_WIDTH-1:0]  inflight;
    logic [CNT_WIDTH-1:0]  count;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];

    logic [CNT_WIDTH:0]    credit_sum;
    logic                  rd_en;
    logic                  pop;
    logic                  push;
    logic                  unexpected;
    logic                  overflow;

    always_comb begin
        // One extra bit so inflight+count cannot wrap below the limit.
        credit_sum = {1'b0, inflight} + {1'b0, count};
        rd_en      = !rst && !bus.fifo_empty && (credit_sum < CREDIT_LIMIT);
        pop        = (count != '0) && bus.m_ready;
        unexpected = bus.fifo_rd_valid && (inflight == '0);
        // A word arriving on a full buffer is only safe if a pop frees the
        // slot in the same cycle; otherwise it is dropped.
        overflow   = bus.fifo_rd_valid && (count == FULL_CNT) && !pop;
        push       = bus.fifo_rd_valid && !overflow;
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = (count != '0);
    assign bus.m_data     = mem[rd_ptr];
    assign bus.level      = count;
    assign bus.err        = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            err_q    <= 1'b0;
        end else begin
            case ({rd_en, bus.fifo_rd_valid})
                2'b10:   inflight <= inflight + CNT_WIDTH'(1);
                // Unexpected data leaves inflight parked at zero.
                2'b01:   if (inflight != '0) inflight <= inflight - CNT_WIDTH'(1);
                default: ;
            endcase

            case ({push, pop})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: ;
            endcase

            if (push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);

            if (unexpected || overflow) err_q <= 1'b1;
        end
    end

    // Storage is not reset; only occupancy decides what is visible.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.fifo_rd_data;
    end
endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_stream_adapter
// Bench for fifo_rd_stream_adapter with default parameters. A FIFO model with a
// READ_LATENCY-deep read pipeline feeds the DUT; a reference model tracks words
// requested-but-not-arrived and words buffered-but-not-consumed, and a
// scoreboard queue holds the expected output order.
// -----------------------------------------------------------------------------
module tb_fifo_rd_stream_adapter;
    localparam int DW = 36;
    localparam int RL = 10;
    localparam int SD = 16;
    localparam int CW = 5;
    localparam logic [DW-1:0] INJ_WORD = 36'hBADBADBAD;

    typedef struct {
        logic          rst;
        logic          empty;
        logic          vld;
        logic [DW-1:0] dat;
        logic          rdy;
        logic          e_en;
        logic          e_mv;
        logic [CW-1:0] e_lvl;
        logic          e_err;
        logic          chk_d;
        logic [DW-1:0] e_d;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_rd_stream_adapter_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    fifo_rd_stream_adapter #(
        .DATA_WIDTH(DW), .READ_LATENCY(RL), .SKID_DEPTH(SD), .CNT_WIDTH(CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // FIFO model and reference state
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] exp_q[$];
    logic [RL-1:0] vld_pipe;
    logic [DW-1:0] dat_pipe[RL];
    int            mdl_cnt, mdl_infl;
    logic          exp_err;
    logic          force_empty, rdy, inj;
    logic          prev_hold;
    logic [DW-1:0] prev_d;
    logic          seen_en, seen_mv, last_mv, stall_seen;
    int            n_chk, n_fail, cyc, n_out, n_issued, max_level, en_cyc, mv_cyc, gaps;
    vec_t          vec[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_model();
        src_q.delete();
        exp_q.delete();
        vld_pipe  = '0;
        mdl_cnt   = 0;
        mdl_infl  = 0;
        exp_err   = 1'b0;
        prev_hold = 1'b0;
        inj       = 1'b0;
        n_out     = 0;
        n_issued  = 0;
        max_level = 0;
    endtask

    // One clock: drive inputs, sample/check at negedge, advance model after posedge.
    task automatic cycle();
        logic          s_en, s_mv, s_v, s_pop;
        logic [DW-1:0] s_d;
        bus.fifo_empty    = force_empty || (src_q.size() == 0);
        bus.m_ready       = rdy;
        bus.fifo_rd_valid = vld_pipe[RL-1] || inj;
        bus.fifo_rd_data  = inj ? INJ_WORD : dat_pipe[RL-1];
        @(negedge clk);
        s_en = bus.fifo_rd_en;
        s_mv = bus.m_valid;
        s_d  = bus.m_data;
        s_v  = vld_pipe[RL-1];
        chk("fifo_rd_en", s_en, !rst && !bus.fifo_empty && (mdl_infl + mdl_cnt < SD));
        chk("m_valid", s_mv, mdl_cnt != 0);
        chk("level", bus.level, mdl_cnt);
        chk("err", bus.err, exp_err);
        chk("credit_bound", int'(bus.level) + mdl_infl <= SD, 1);
        if (mdl_cnt != 0) chk("m_data", s_d, exp_q[0]);
        if (prev_hold) begin
            chk("hold_valid", s_mv, 1);
            chk("hold_data", s_d, prev_d);
        end
        prev_hold = s_mv && !rdy;
        prev_d    = s_d;
        if (!s_en && !rst && !bus.fifo_empty) stall_seen = 1'b1;
        if (s_en && !seen_en) begin seen_en = 1'b1; en_cyc = cyc; end
        if (s_mv && !seen_mv) begin seen_mv = 1'b1; mv_cyc = cyc; end
        last_mv = s_mv;
        @(posedge clk);
        #1;
        cyc++;
        s_pop = (mdl_cnt != 0) && rdy;
        if (s_pop) begin
            void'(exp_q.pop_front());
            n_out++;
        end
        mdl_cnt  += (s_v ? 1 : 0) - (s_pop ? 1 : 0);
        mdl_infl += (s_en ? 1 : 0) - (s_v ? 1 : 0);
        if (mdl_cnt > max_level) max_level = mdl_cnt;
        for (int i = RL - 1; i > 0; i--) begin
            vld_pipe[i] = vld_pipe[i-1];
            dat_pipe[i] = dat_pipe[i-1];
        end
        vld_pipe[0] = s_en && (src_q.size() != 0);
        if (vld_pipe[0]) begin
            dat_pipe[0] = src_q.pop_front();
            exp_q.push_back(dat_pipe[0]);
            n_issued++;
        end
        if (inj) begin
            exp_err = 1'b1;
            inj     = 1'b0;
        end
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset(input int n);
        rst = 1'b1;
        clear_model();
        bus.fifo_rd_valid = 1'b0;
        #1;
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_level", bus.level, 0);
        chk("rst_rd_en", bus.fifo_rd_en, 0);
        chk("rst_err", bus.err, 0);
        repeat (n) cycle();
        rst = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        rst               = v.rst;
        bus.fifo_empty    = v.empty;
        bus.fifo_rd_valid = v.vld;
        bus.fifo_rd_data  = v.dat;
        bus.m_ready       = v.rdy;
        @(negedge clk);
        chk($sformatf("vec%0d_rd_en", idx), bus.fifo_rd_en, v.e_en);
        chk($sformatf("vec%0d_m_valid", idx), bus.m_valid, v.e_mv);
        chk($sformatf("vec%0d_level", idx), bus.level, v.e_lvl);
        chk($sformatf("vec%0d_err", idx), bus.err, v.e_err);
        if (v.chk_d) chk($sformatf("vec%0d_m_data", idx), bus.m_data, v.e_d);
        @(posedge clk);
        #1;
    endtask

    initial begin
        //        rst   emp   vld   dat         rdy   en    mv    lvl  err  chk_d e_d
        vec[0] = '{1'b1, 1'b1, 1'b0, '0,         1'b0, 1'b0, 1'b0, 0,   1'b0, 1'b0, '0};
        vec[1] = '{1'b0, 1'b1, 1'b0, '0,         1'b0, 1'b0, 1'b0, 0,   1'b0, 1'b0, '0};
        vec[2] = '{1'b0, 1'b1, 1'b1, 36'h123456789, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, '0};
        vec[3] = '{1'b0, 1'b1, 1'b0, '0,         1'b0, 1'b0, 1'b1, 1,   1'b1, 1'b1, 36'h123456789};
        vec[4] = '{1'b0, 1'b1, 1'b0, '0,         1'b1, 1'b0, 1'b1, 1,   1'b1, 1'b1, 36'h123456789};
        vec[5] = '{1'b0, 1'b1, 1'b0, '0,         1'b1, 1'b0, 1'b0, 0,   1'b1, 1'b0, '0};
        vec[6] = '{1'b1, 1'b1, 1'b0, '0,         1'b0, 1'b0, 1'b0, 0,   1'b0, 1'b0, '0};
        vec[7] = '{1'b0, 1'b0, 1'b0, '0,         1'b0, 1'b1, 1'b0, 0,   1'b0, 1'b0, '0};
        vec[8] = '{1'b0, 1'b1, 1'b0, '0,         1'b0, 1'b0, 1'b0, 0,   1'b0, 1'b0, '0};
        vec[9] = '{1'b1, 1'b0, 1'b0, '0,         1'b0, 1'b0, 1'b0, 0,   1'b0, 1'b0, '0};

        n_chk = 0; n_fail = 0; cyc = 0;
        force_empty = 1'b0; rdy = 1'b0; stall_seen = 1'b0;
        seen_en = 1'b0; seen_mv = 1'b0; last_mv = 1'b0;
        en_cyc = 0; mv_cyc = 0; gaps = 0;
        bus.fifo_rd_data = '0;

        // Idle with an empty FIFO.
        do_reset(3);
        repeat (50) cycle();

        // Directed vectors: unexpected data sets sticky err, reset clears it.
        for (int i = 0; i < 10; i++) apply_vec(vec[i], i);

        // Full-throughput stream 0..99.
        do_reset(3);
        for (int i = 0; i < 100; i++) src_q.push_back(DW'(i));
        rdy = 1'b1; seen_en = 1'b0; seen_mv = 1'b0; gaps = 0;
        for (int k = 0; k < 400 && n_out < 100; k++) begin
            cycle();
            if (seen_mv && !last_mv) gaps++;
        end
        chk("first_latency", mv_cyc - en_cyc, RL + 1);
        chk("stream_gaps", gaps, 0);
        chk("stream_words", n_out, 100);

        // Backpressure: stall 40 cycles, inject a word into the full buffer.
        do_reset(3);
        for (int i = 0; i < 100; i++) src_q.push_back(DW'(i));
        rdy = 1'b1; stall_seen = 1'b0;
        repeat (5) cycle();
        rdy = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (k == 35 && mdl_infl == 0 && mdl_cnt == SD) inj = 1'b1;
            cycle();
        end
        chk("bp_peak_level", max_level, SD);
        chk("bp_credit_stall", stall_seen, 1);
        chk("bp_overflow_err", bus.err, 1);
        chk("bp_level_after_drop", bus.level, SD);
        rdy = 1'b1;
        for (int k = 0; k < 400 && n_out < 100; k++) cycle();
        chk("bp_words", n_out, 100);

        // Random backpressure and random FIFO empty.
        do_reset(2);
        for (int i = 0; i < 300; i++) src_q.push_back({4'($urandom), 32'($urandom)});
        rdy = 1'b1;
        for (int k = 0; k < 6000 && n_out < 300; k++) begin
            if ($urandom_range(0, 99) < 30) rdy = !rdy;
            force_empty = ($urandom_range(0, 99) < 20);
            cycle();
        end
        force_empty = 1'b0;
        chk("rand_words", n_out, 300);

        // Reset with 5 words in flight and 8 buffered.
        do_reset(2);
        for (int i = 0; i < 50; i++) src_q.push_back(DW'(i + 500));
        rdy = 1'b0;
        for (int k = 0; k < 50 && n_issued < 13; k++) cycle();
        force_empty = 1'b1;
        for (int k = 0; k < 50 && mdl_cnt < 8; k++) cycle();
        chk("midrst_buffered", bus.level, 8);
        chk("midrst_inflight", mdl_infl, 5);
        #2;
        do_reset(3);
        force_empty = 1'b0;
        for (int i = 0; i < 20; i++) src_q.push_back(DW'(i + 1000));
        rdy = 1'b1;
        for (int k = 0; k < 100 && n_out < 5; k++) cycle();
        chk("midrst_words_after", n_out, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_rd_stream_adapter.md
Name: fifo_rd_stream_adapter

Overview:
- Sits directly downstream of the asynchronous FIFO's read port, in the read clock domain.
- Converts the FIFO's rd_en / pipelined rd_data+rd_valid interface, which has fixed multi-cycle read latency, into a valid/ready stream with full throughput and backpressure.
- Prefetches words into a local skid buffer under credit control, so words already in the RAM output pipeline are never dropped when the consumer stalls.

Parameters:
- DATA_WIDTH, 36: width of FIFO read data and stream data.
- READ_LATENCY, 10: exact cycles from fifo_rd_en high to the matching fifo_rd_valid high; must be >= 1.
- SKID_DEPTH, 16: local buffer entries; must be >= READ_LATENCY+1 for full throughput. A power of two is required.
- CNT_WIDTH, $clog2(SKID_DEPTH)+1: width of the occupancy and credit counters.

Ports:
- clk  in  1  read-domain clock.
- rst  in  1  asynchronous, active-high reset.
- fifo_empty  in  1  empty flag from the FIFO read controller.
- fifo_rd_en  out  1  read request to the FIFO.
- fifo_rd_data  in  DATA_WIDTH  FIFO read data; meaningful only when fifo_rd_valid is high.
- fifo_rd_valid  in  1  FIFO read-data valid.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_data  out  DATA_WIDTH  stream data.
- level  out  CNT_WIDTH  number of words currently held in the skid buffer.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset is asynchronous and active-high. It clears inflight, count, rd_ptr, wr_ptr and err to 0.
  - While rst is high: fifo_rd_en=0, m_valid=0, level=0.
  - m_data is don't-care during reset. Buffer contents are not reset.
- inflight counter (CNT_WIDTH bits):
  - +1 on fifo_rd_en.
  - -1 on fifo_rd_valid.
  - Both in the same cycle: unchanged.
- count counter (CNT_WIDTH bits), meaning buffer occupancy:
  - +1 on push (fifo_rd_valid).
  - -1 on pop (m_valid && m_ready).
  - Both in the same cycle: unchanged.
- Credit rule: fifo_rd_en = !rst && !fifo_empty && (inflight + count < SKID_DEPTH).
  - This is combinational from registered counters plus the fifo_empty input.
  - The sum is computed at CNT_WIDTH+1 bits, with no wrap.
  - A pop in the current cycle does not grant credit until the next cycle.
- Push:
  - On fifo_rd_valid, write fifo_rd_data to mem[wr_ptr].
  - wr_ptr increments modulo SKID_DEPTH.
- Pop:
  - m_valid = (count != 0).
  - m_data = mem[rd_ptr], read combinationally (distributed/register storage).
  - On m_valid && m_ready, rd_ptr increments modulo SKID_DEPTH.
- Simultaneous push and pop:
  - Both happen.
  - When count==0, a pushed word appears on m_data in the next cycle. There is no same-cycle bypass.
- Latency and throughput:
  - First word appears at m_valid READ_LATENCY+1 cycles after the first fifo_rd_en.
  - Sustained throughput is 1 word/cycle with m_ready held high and the FIFO non-empty.
- Stream rule: once m_valid is high, m_valid and m_data are held stable until accepted. This is guaranteed by the buffer ordering.
- Error conditions; each sets err=1 and err holds until reset:
  - fifo_rd_valid while inflight==0 (unexpected data). inflight saturates at 0.
  - fifo_rd_valid while count==SKID_DEPTH and there is no pop (overflow). The word is dropped and wr_ptr holds.
- Reset mid-operation:
  - Words in flight in the FIFO output pipeline are abandoned.
  - The FIFO must be reset together with this block; after release both sides start empty.
- fifo_empty high: fifo_rd_en is 0. Words already in flight still arrive and are buffered.

Test Plan:
- Reset then idle, fifo_empty=1 -> fifo_rd_en=0, m_valid=0, level=0, err=0 for 50 cycles.
- Default parameters, 100 words 0..99 available, m_ready=1 -> first m_valid 11 cycles after first fifo_rd_en. After that m_valid stays high every cycle. Output is 0..99 in order, err=0.
- Same stream with m_ready=0 from cycle 5 for 40 cycles:
  - fifo_rd_en deasserts once inflight+count=16.
  - level peaks at 16 and no word is lost.
  - On m_ready=1 the output resumes with the next sequential value.
- m_ready toggled randomly at 30% and fifo_empty toggled randomly -> output sequence is exact, inflight+count never exceeds 16, m_data is stable whenever m_valid=1 && m_ready=0.
- Inject fifo_rd_valid with no prior fifo_rd_en -> err=1 the next cycle and it stays 1. Then assert rst -> err=0.
- Assert rst with 5 words in flight and 8 buffered -> m_valid=0, level=0 immediately (asynchronously). After release with a fresh FIFO, the first word is delivered correctly.
